// File: rtl/multi_mode_ff_bank.sv
// multi_mode_ff_bank: WIDTH independent flip-flop channels sharing one mode
// select (SR / JK / D / T), with per-channel illegal-SR flags and an optional
// saturating illegal-cycle counter.
// Optional feature macro: MULTI_MODE_FF_ERRCNT_EN (defined -> err_cnt counter
// implemented; undefined -> err_cnt tied to 0 and err_clr ignored).
module multi_mode_ff_bank #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = {WIDTH{1'b0}},
  parameter int unsigned           CNT_W     = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] invalid,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] inv_q, inv_d;
  mode_e            mode_c;

  assign mode_c = mode_e'(mode);

  // Next channel state and illegal flags; all channels computed bitwise so no
  // channel can see another channel's inputs.
  always_comb begin
    q_d   = q_q;
    inv_d = '0;
    if (en) begin
      case (mode_c)
        MODE_SR: begin
          // set on 10, reset on 01, hold on 00 and on the illegal 11
          q_d   = (s & ~r) | (q_q & ~(s ^ r));
          inv_d = s & r;
        end
        MODE_JK: q_d = (s & ~q_q) | (~r & q_q);
        MODE_D:  q_d = s;
        MODE_T:  q_d = q_q ^ s;
        default: q_d = q_q;
      endcase
    end
  end

  // Channel state and invalid flags; clear discards everything immediately.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q_q   <= RESET_VAL;
      inv_q <= '0;
    end else begin
      q_q   <= q_d;
      inv_q <= inv_d;
    end
  end

  assign q       = q_q;
  assign qbar    = ~q_q;
  assign invalid = inv_q;

`ifdef MULTI_MODE_FF_ERRCNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             illegal_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // One count per illegal cycle regardless of how many channels are illegal.
  assign illegal_c = en && (mode_c == MODE_SR) && (|(s & r));

  // Saturating counter; a clear coinciding with an illegal cycle lands on 1.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = illegal_c ? CNT_W'(1) : '0;
    end else if (illegal_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt = cnt_q;
`else
  logic errcnt_unused;

  // Counter absent: err_clr has no effect and err_cnt is constant zero.
  assign errcnt_unused = err_clr;
  assign err_cnt       = '0;
`endif

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Self-checking bench for multi_mode_ff_bank (WIDTH=8, CNT_W=2).
// Expected err_cnt values follow MULTI_MODE_FF_ERRCNT_EN as seen by the bench.
module tb_multi_mode_ff_bank;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 2;
  localparam logic [W-1:0] RV = 8'h00;
`ifdef MULTI_MODE_FF_ERRCNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  localparam logic [1:0] M_SR = 2'b00;
  localparam logic [1:0] M_JK = 2'b01;
  localparam logic [1:0] M_D  = 2'b10;
  localparam logic [1:0] M_T  = 2'b11;

  logic          clk = 1'b0;
  logic          clear;
  logic          en;
  logic [1:0]    mode;
  logic [W-1:0]  s, r;
  logic          err_clr;
  logic [W-1:0]  q, qbar, invalid;
  logic [CW-1:0] err_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0]  q;
    logic [W-1:0]  inv;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];

  // reference model state for the random test
  logic [W-1:0]  m_q;
  logic [CW-1:0] m_cnt;

  always #5 clk = ~clk;

  multi_mode_ff_bank #(
    .WIDTH    (W),
    .RESET_VAL(RV),
    .CNT_W    (CW)
  ) dut (
    .clk    (clk),
    .clear  (clear),
    .en     (en),
    .mode   (mode),
    .s      (s),
    .r      (r),
    .err_clr(err_clr),
    .q      (q),
    .qbar   (qbar),
    .invalid(invalid),
    .err_cnt(err_cnt)
  );

  function automatic logic [CW-1:0] ce(input int unsigned v);
    return CNT_ON ? CW'(v) : '0;
  endfunction

  // Drive one cycle's inputs at the falling edge, push the expectation, and
  // return 1ns after the rising edge that samples them.
  task automatic drive(input logic e, input logic [1:0] md, input logic [W-1:0] sv,
                       input logic [W-1:0] rv, input logic ec, input logic [W-1:0] xq,
                       input logic [W-1:0] xinv, input logic [CW-1:0] xcnt);
    exp_t x;
    @(negedge clk);
    en = e; mode = md; s = sv; r = rv; err_clr = ec;
    x.q = xq; x.inv = xinv; x.cnt = xcnt;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t x;
    clear = 1'b0; en = 1'b0; mode = M_SR; s = '0; r = '0; err_clr = 1'b0;
    #1;
    tests++; if (q !== RV) begin fails++; $display("FAIL reset_q got %h want %h", q, RV); end
    tests++; if (qbar !== ~RV) begin fails++; $display("FAIL reset_qbar got %h want %h", qbar, ~RV); end
    tests++; if (invalid !== '0) begin fails++; $display("FAIL reset_inv got %h want 00", invalid); end
    tests++; if (err_cnt !== '0) begin fails++; $display("FAIL reset_cnt got %h want 0", err_cnt); end
    // inputs ignored while clear is low
    drive(1'b1, M_D, 8'hFF, 8'h00, 1'b0, RV, 8'h00, '0);
    x = sb.pop_front();
    tests++; if (q !== x.q) begin fails++; $display("FAIL reset_hold_q got %h want %h", q, x.q); end
    @(negedge clk); clear = 1'b1;
    // first edge after release loads
    drive(1'b1, M_D, 8'hA5, 8'h00, 1'b0, 8'hA5, 8'h00, ce(0));
    x = sb.pop_front();
    tests++; if (q !== x.q) begin fails++; $display("FAIL release_q got %h want %h", q, x.q); end
    drive(1'b1, M_SR, 8'h03, 8'h03, 1'b0, 8'hA5, 8'h03, ce(1));
    x = sb.pop_front();
    tests++; if (invalid !== x.inv) begin fails++; $display("FAIL pre_rst_inv got %h want %h", invalid, x.inv); end
    tests++; if (err_cnt !== x.cnt) begin fails++; $display("FAIL pre_rst_cnt got %h want %h", err_cnt, x.cnt); end
    // mid-cycle assertion with an update in flight
    en = 1'b1; mode = M_D; s = 8'hFF;
    #2; clear = 1'b0;
    #1;
    tests++; if (q !== 8'h00) begin fails++; $display("FAIL async_q got %h want 00", q); end
    tests++; if (qbar !== 8'hFF) begin fails++; $display("FAIL async_qbar got %h want ff", qbar); end
    tests++; if (invalid !== 8'h00) begin fails++; $display("FAIL async_inv got %h want 00", invalid); end
    tests++; if (err_cnt !== '0) begin fails++; $display("FAIL async_cnt got %h want 0", err_cnt); end
    @(posedge clk); #1;
    tests++; if (q !== 8'h00) begin fails++; $display("FAIL async_hold_q got %h want 00", q); end
    @(negedge clk); clear = 1'b1; en = 1'b0;
  endtask

  task automatic test_sr();
    exp_t x;
    drive(1'b1, M_SR, 8'h0F, 8'hF0, 1'b0, 8'h0F, 8'h00, ce(0));
    drive(1'b1, M_SR, 8'h03, 8'h03, 1'b0, 8'h0F, 8'h03, ce(1));
    for (int i = 0; i < 2; i++) begin
      if (i == 1) begin
        x = sb.pop_front();
        tests++; if (q !== x.q) begin fails++; $display("FAIL sr_q got %h want %h", q, x.q); end
        tests++; if (qbar !== ~x.q) begin fails++; $display("FAIL sr_qbar got %h want %h", qbar, ~x.q); end
        tests++; if (invalid !== x.inv) begin fails++; $display("FAIL sr_inv got %h want %h", invalid, x.inv); end
        tests++; if (err_cnt !== x.cnt) begin fails++; $display("FAIL sr_cnt got %h want %h", err_cnt, x.cnt); end
      end else begin
        // first entry was already overwritten by the second cycle's output
        x = sb.pop_front();
        tests++; if (x.q !== 8'h0F || q === 8'h00) begin fails++; $display("FAIL sr_set got %h want %h", q, x.q); end
      end
    end
  endtask

  task automatic test_jk();
    exp_t x;
    logic [W-1:0] want[2] = '{8'hF0, 8'h0F};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, M_JK, 8'hFF, 8'hFF, 1'b0, want[i], 8'h00, ce(1));
      x = sb.pop_front();
      tests++; if (q !== x.q) begin fails++; $display("FAIL jk_q[%0d] got %h want %h", i, q, x.q); end
      tests++; if (invalid !== x.inv) begin fails++; $display("FAIL jk_inv[%0d] got %h want %h", i, invalid, x.inv); end
    end
    drive(1'b1, M_JK, 8'h30, 8'h0C, 1'b0, 8'h33, 8'h00, ce(1));
    x = sb.pop_front();
    tests++; if (q !== x.q) begin fails++; $display("FAIL jk_setrst got %h want %h", q, x.q); end
  endtask

  task automatic test_dt();
    exp_t x;
    drive(1'b1, M_D, 8'h5A, 8'hFF, 1'b0, 8'h5A, 8'h00, ce(1));
    x = sb.pop_front();
    tests++; if (q !== x.q) begin fails++; $display("FAIL d_q got %h want %h", q, x.q); end
    drive(1'b1, M_T, 8'h01, 8'hFF, 1'b0, 8'h5B, 8'h00, ce(1));
    x = sb.pop_front();
    tests++; if (q !== x.q) begin fails++; $display("FAIL t_q got %h want %h", q, x.q); end
    drive(1'b0, M_T, 8'hFF, 8'h00, 1'b0, 8'h5B, 8'h00, ce(1));
    x = sb.pop_front();
    tests++; if (q !== x.q) begin fails++; $display("FAIL en0_q got %h want %h", q, x.q); end
    tests++; if (qbar !== ~x.q) begin fails++; $display("FAIL en0_qbar got %h want %h", qbar, ~x.q); end
  endtask

  task automatic test_counter();
    exp_t x;
    int unsigned seq[5] = '{1, 2, 3, 3, 3};
    drive(1'b1, M_D, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, ce(0));
    x = sb.pop_front();
    tests++; if (err_cnt !== x.cnt) begin fails++; $display("FAIL cnt_clr0 got %h want %h", err_cnt, x.cnt); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, M_SR, 8'h01, 8'h01, 1'b0, 8'h00, 8'h01, ce(seq[i]));
      x = sb.pop_front();
      tests++; if (err_cnt !== x.cnt) begin fails++; $display("FAIL cnt_sat[%0d] got %h want %h", i, err_cnt, x.cnt); end
      tests++; if (invalid !== x.inv) begin fails++; $display("FAIL cnt_inv[%0d] got %h want %h", i, invalid, x.inv); end
    end
    drive(1'b1, M_SR, 8'h01, 8'h01, 1'b1, 8'h00, 8'h01, ce(1));
    x = sb.pop_front();
    tests++; if (err_cnt !== x.cnt) begin fails++; $display("FAIL cnt_clr_inc got %h want %h", err_cnt, x.cnt); end
    drive(1'b1, M_SR, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, ce(0));
    x = sb.pop_front();
    tests++; if (err_cnt !== x.cnt) begin fails++; $display("FAIL cnt_clr got %h want %h", err_cnt, x.cnt); end
    drive(1'b0, M_SR, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, ce(0));
    x = sb.pop_front();
    tests++; if (invalid !== x.inv) begin fails++; $display("FAIL en0_inv got %h want %h", invalid, x.inv); end
    tests++; if (err_cnt !== x.cnt) begin fails++; $display("FAIL en0_cnt got %h want %h", err_cnt, x.cnt); end
  endtask

  // Random back-to-back traffic with mode changes every cycle, checked
  // against a per-channel behavioural model.
  task automatic test_back_to_back();
    exp_t x, nx;
    logic e, ec, ill;
    logic [1:0] md;
    logic [W-1:0] sv, rv;
    drive(1'b1, M_D, 8'hC3, 8'h00, 1'b1, 8'hC3, 8'h00, ce(0));
    x = sb.pop_front();
    tests++; if (q !== x.q) begin fails++; $display("FAIL b2b_init got %h want %h", q, x.q); end
    m_q = 8'hC3; m_cnt = '0;
    for (int n = 0; n < 300; n++) begin
      e  = ($urandom_range(0, 3) != 0);
      md = 2'($urandom_range(0, 3));
      sv = 8'($urandom);
      rv = 8'($urandom);
      ec = ($urandom_range(0, 7) == 0);
      nx.inv = '0;
      for (int b = 0; b < W; b++) begin
        if (e) begin
          case (md)
            M_SR: begin
              if (sv[b] && !rv[b]) m_q[b] = 1'b1;
              else if (!sv[b] && rv[b]) m_q[b] = 1'b0;
              else if (sv[b] && rv[b]) nx.inv[b] = 1'b1;
            end
            M_JK: begin
              if (sv[b] && rv[b]) m_q[b] = ~m_q[b];
              else if (sv[b]) m_q[b] = 1'b1;
              else if (rv[b]) m_q[b] = 1'b0;
            end
            M_D: m_q[b] = sv[b];
            default: if (sv[b]) m_q[b] = ~m_q[b];
          endcase
        end
      end
      ill = (nx.inv != '0);
      if (CNT_ON) begin
        if (ec) m_cnt = ill ? CW'(1) : '0;
        else if (ill && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + CW'(1);
      end
      drive(e, md, sv, rv, ec, m_q, nx.inv, m_cnt);
      x = sb.pop_front();
      tests++; if (q !== x.q) begin fails++; $display("FAIL b2b_q[%0d] got %h want %h", n, q, x.q); end
      tests++; if (qbar !== ~x.q) begin fails++; $display("FAIL b2b_qbar[%0d] got %h want %h", n, qbar, ~x.q); end
      tests++; if (invalid !== x.inv) begin fails++; $display("FAIL b2b_inv[%0d] got %h want %h", n, invalid, x.inv); end
      tests++; if (err_cnt !== x.cnt) begin fails++; $display("FAIL b2b_cnt[%0d] got %h want %h", n, err_cnt, x.cnt); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sr();
    test_jk();
    test_dt();
    test_counter();
    test_back_to_back();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_empty got %0d want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_mode_ff_bank.md
MULTI_MODE_FF_BANK -- requirements
Module: multi_mode_ff_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of independent flip-flop channels, legal range 1..32.
REQ-002 Parameter RESET_VAL, default {WIDTH{1'b0}}: value loaded into q on reset.
REQ-003 Parameter CNT_W, default 8: width of the illegal-condition counter, legal range 1..16.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 clear  input  1: asynchronous, active-low reset.
REQ-006 en  input  1: when 1, channels update this edge; when 0, every channel holds.
REQ-007 mode  input  2: shared channel mode (00 SR, 01 JK, 10 D, 11 T).
REQ-008 s  input  WIDTH: per-channel S / J / D / T input.
REQ-009 r  input  WIDTH: per-channel R / K input; ignored in D and T modes.
REQ-010 err_clr  input  1: synchronous clear of err_cnt.
REQ-011 q  output  WIDTH: registered channel state.
REQ-012 qbar  output  WIDTH: bitwise complement of q, derived from the same register, never independently stored.
REQ-013 invalid  output  WIDTH: registered per-channel flag for illegal SR input.
REQ-014 err_cnt  output  CNT_W: saturating count of cycles with an illegal SR input.

Function
REQ-015 The block SHALL sample inputs and update q one edge after they are presented (latency 1); there is no combinational path from s/r to q.
REQ-016 In SR mode, each channel SHALL apply s=1,r=0 -> q=1; s=0,r=1 -> q=0; s=0,r=0 -> hold; s=1,r=1 -> hold and invalid bit = 1.
REQ-017 In JK mode, each channel SHALL apply 10 -> set; 01 -> reset; 00 -> hold; 11 -> toggle. invalid stays 0.
REQ-018 In D mode, each channel SHALL load q=s.
REQ-019 In T mode, each channel SHALL toggle when s=1 and hold when s=0.
REQ-020 Channels SHALL be fully independent; one channel's inputs never affect another channel's q or invalid.
REQ-021 invalid SHALL be recomputed every edge and reflect only the current edge's sample; it is 0 when en=0 or mode is not SR.
REQ-022 A mode change SHALL take effect on the same edge that samples the new mode; q carries over unchanged across the change.
REQ-023 When en=0, q SHALL hold and invalid SHALL be 0; err_cnt SHALL still honour err_clr.
REQ-024 err_cnt SHALL increment by 1 on each edge where en=1, mode=SR and any channel has s=r=1. The increment is per cycle, not per channel.
REQ-025 err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 If err_clr=1 and an increment condition occur on the same edge, err_cnt SHALL become 1. If err_clr=1 alone, err_cnt SHALL become 0.

Reset
REQ-027 When clear=0, the block SHALL immediately, without waiting for clk, set q=RESET_VAL, qbar=~RESET_VAL, invalid=0 and err_cnt=0.
REQ-028 While clear=0, all inputs SHALL be ignored.
REQ-029 The first update after release SHALL occur on the first rising clk edge with clear=1.
REQ-030 Assertion of clear mid-operation, including between clock edges, SHALL discard the in-flight state with no glitch to non-reset values.

Configuration
REQ-031 Macro MULTI_MODE_FF_ERRCNT_EN defined: the counter of REQ-024..026 SHALL be implemented.
REQ-032 Macro MULTI_MODE_FF_ERRCNT_EN undefined: err_cnt SHALL be tied to 0, err_clr ignored, no counter flops inferred; invalid behaviour unchanged.

Verification
REQ-033 Reset: clear=0 at t=3ns mid-cycle with q=8'hA5 -> q=8'h00, qbar=8'hFF, err_cnt=0 before the next clk edge.
REQ-034 SR sweep, WIDTH=8: s=8'h0F, r=8'hF0 -> q=8'h0F. Then s=8'h03, r=8'h03 -> q holds 8'h0F, invalid=8'h03, err_cnt=1.
REQ-035 JK toggle: q=8'h0F, mode=01, s=r=8'hFF for 2 cycles -> q=8'hF0 then 8'h0F, invalid=0.
REQ-036 D/T: mode=10, s=8'h5A -> q=8'h5A. Then mode=11, s=8'h01 -> q=8'h5B. Then en=0 with s=8'hFF -> q holds 8'h5B.
REQ-037 Counter (macro on, CNT_W=2): 5 consecutive illegal SR cycles -> err_cnt 1,2,3,3,3. Then err_clr with illegal input -> 1. Then err_clr alone -> 0.
REQ-038 Macro off: repeat REQ-037 stimulus -> err_cnt=0 throughout, invalid identical to macro-on run.
